// File: rtl/glip_stream_gen_pkg.sv
// Shared encodings for the GLIP stream generator: pattern selects and FSM states.
// No logic lives here.
package glip_stream_gen_pkg;

  localparam logic [1:0] PAT_COUNT = 2'd0;
  localparam logic [1:0] PAT_LFSR  = 2'd1;
  localparam logic [1:0] PAT_WALK  = 2'd2;
  localparam logic [1:0] PAT_CONST = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/glip_stream_pattern.sv
// Pattern word register: load picks the first word of the selected pattern, advance steps it.
// One-cycle update; the caller decides when a word is consumed, so this block has no backpressure of its own.
module glip_stream_pattern
  import glip_stream_gen_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             advance,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] data
);

  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [WIDTH-1:0] SEED_NZ = (SEED == '0) ? WIDTH'(1) : SEED;

  logic [1:0] sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      sel_q <= PAT_COUNT;
    end else if (load) begin
      sel_q <= sel;
      case (sel)
        PAT_COUNT: data <= '0;
        PAT_LFSR:  data <= SEED_NZ;
        PAT_WALK:  data <= WIDTH'(1);
        default:   data <= SEED_NZ;
      endcase
    end else if (advance) begin
      case (sel_q)
        PAT_COUNT: data <= data + WIDTH'(1);
        PAT_LFSR:  data <= (data >> 1) ^ (data[0] ? TAPS : '0);
        PAT_WALK:  data <= {data[WIDTH-2:0], data[WIDTH-1]};
        default:   data <= data;
      endcase
    end
  end

endmodule

// File: rtl/glip_stream_gen.sv
// GLIP FPGA->host traffic source: counter/LFSR/walking-one/constant words on a valid/ready stream.
// First word valid the cycle after start, 1 word/cycle sustained; valid is held until accepted, even across stop.
module glip_stream_gen
  import glip_stream_gen_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               LEN_WIDTH = 32,
  parameter int               GAP_WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED      = 16'hACE1,
  parameter logic [WIDTH-1:0] TAPS      = 16'hB400
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [1:0]           pattern_sel,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic [GAP_WIDTH-1:0] gap,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_WIDTH-1:0] words_sent
);

  state_t               state, state_nxt;
  logic [LEN_WIDTH-1:0] len_q;
  logic [GAP_WIDTH-1:0] gap_q;
  logic [GAP_WIDTH-1:0] gap_cnt;
  logic                 stop_pend;
  logic                 hs;
  logic                 last_word;
  logic                 load;
  logic                 advance;
  logic                 end_run;
  logic                 enter_gap;

  assign out_valid = (state == ST_SEND);
  assign busy      = (state != ST_IDLE);
  assign hs        = out_valid & out_ready;
  // Wraps to 0 once words_sent saturates, so a saturated counter never matches a nonzero len.
  assign last_word = (len_q != '0) && ((words_sent + LEN_WIDTH'(1)) == len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    end_run   = 1'b0;
    enter_gap = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          load      = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (hs) begin
          advance = 1'b1;
          if (last_word || stop_pend || stop) begin
            end_run   = 1'b1;
            state_nxt = ST_IDLE;
          end else if (gap_q != '0) begin
            enter_gap = 1'b1;
            state_nxt = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (stop) begin
          end_run   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (gap_cnt <= GAP_WIDTH'(1)) begin
          state_nxt = ST_SEND;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      gap_q      <= '0;
      gap_cnt    <= '0;
      stop_pend  <= 1'b0;
      words_sent <= '0;
      done       <= 1'b0;
    end else begin
      done <= end_run;
      if (load) begin
        len_q      <= len;
        gap_q      <= gap;
        words_sent <= '0;
        stop_pend  <= 1'b0;
      end else begin
        if (advance && (words_sent != '1)) words_sent <= words_sent + LEN_WIDTH'(1);
        if (end_run)                         stop_pend  <= 1'b0;
        else if (state == ST_SEND && stop)   stop_pend  <= 1'b1;
      end
      if (enter_gap)            gap_cnt <= gap_q;
      else if (state == ST_GAP) gap_cnt <= gap_cnt - GAP_WIDTH'(1);
    end
  end

  glip_stream_pattern #(
    .WIDTH (WIDTH),
    .SEED  (SEED),
    .TAPS  (TAPS)
  ) u_pattern (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .advance (advance),
    .sel     (pattern_sel),
    .data    (out_data)
  );

endmodule
